// File: rtl/bus_pkg.sv
// bus_pkg: bus size codes, responder state encodings and the reset vector shared by bus targets.
package bus_pkg;
  typedef enum logic [1:0] {
    SIZE_NONE = 2'b00,
    SIZE_BYTE = 2'b01,
    SIZE_HALF = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_e;
  localparam logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;
endpackage

// File: rtl/fetch_responder_if.sv
// fetch_responder_if: initiator-facing read bus between the fetch unit and a bus target.
interface fetch_responder_if;
  logic [63:0] adr;
  logic [1:0]  size;
  logic        vpa;
  logic        ack;
  logic [15:0] dat;
  logic        err;
  logic        fetch_err;
  modport master (output adr, size, vpa, input ack, dat, err, fetch_err);
  modport slave  (input adr, size, vpa, output ack, dat, err, fetch_err);
endinterface

// File: rtl/bus_wait_counter.sv
// bus_wait_counter: loadable down-counter with zero flag, used to insert wait states.
module bus_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (dec_i) cnt_q <= cnt_q - W'(1);
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/fetch_responder.sv
// fetch_responder: single-window bus target reading a synchronous SRAM/ROM with programmable wait states.
module fetch_responder
  import bus_pkg::*;
#(
  parameter logic [63:0] BASE        = RESET_VECTOR,
  parameter int          AW          = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  fetch_responder_if.slave  bus,
  output logic              mem_en_o,
  output logic [AW-2:0]     mem_adr_o,
  input  logic [15:0]       mem_dat_i
);
  state_e      state_q;
  logic [1:0]  size_q;
  logic        adr0_q, first_q, ack_q, err_q, fetch_err_q;
  logic [15:0] word_q, dat_q, word_d, sel_d;
  logic        req, hit, ill, load, cnt_zero;
  assign req       = bus.size != SIZE_NONE;
  assign hit       = bus.adr[63:AW] == BASE[63:AW];
  assign ill       = bus.size == SIZE_ILL;
  assign load      = state_q == IDLE && req && hit && !ill;
  assign mem_en_o  = load;
  assign mem_adr_o = bus.adr[AW-1:1];
  // SRAM data is only valid on the first READ cycle; later cycles use the captured copy
  assign word_d    = first_q ? mem_dat_i : word_q;
  assign sel_d     = size_q == SIZE_BYTE ? {8'h00, adr0_q ? word_d[15:8] : word_d[7:0]} : word_d;
  bus_wait_counter #(.W(4)) u_cnt (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (load),
    .dec_i      (state_q == READ && !cnt_zero),
    .load_val_i (4'(WAIT_STATES)),
    .zero_o     (cnt_zero)
  );
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      size_q      <= SIZE_NONE;
      adr0_q      <= 1'b0;
      first_q     <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      fetch_err_q <= 1'b0;
      word_q      <= '0;
      dat_q       <= '0;
    end else begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          adr0_q <= bus.adr[0];
          size_q <= bus.size;
          if (hit && !ill) begin
            state_q <= READ;
            first_q <= 1'b1;
          end else begin
            state_q     <= ACK;
            ack_q       <= 1'b1;
            err_q       <= 1'b1;
            fetch_err_q <= bus.vpa;
            dat_q       <= '0;
          end
        end
        READ: begin
          first_q <= 1'b0;
          word_q  <= word_d;
          if (bus.size == SIZE_NONE) state_q <= IDLE;
          else if (cnt_zero) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            dat_q   <= sel_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.fetch_err = fetch_err_q;
  assign bus.dat       = dat_q;
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: three responders (0, 3, 5 wait states) driven by directed reads; a monitor scores acks.
module tb_fetch_responder;
  import bus_pkg::*;
  localparam logic [63:0] B = RESET_VECTOR;
  typedef struct {
    logic [15:0] dat;
    logic        err;
    logic        ferr;
    int          lat;
    int          issue;
  } exp_t;
  logic        clk_i = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] adr[3];
  logic [1:0]  size[3];
  logic        vpa[3];
  logic [2:0]  ack, err, ferr, mem_en;
  logic [15:0] dat[3];
  logic [6:0]  madr[3];
  logic [15:0] mdat[3];
  logic [15:0] mem[128];
  exp_t        sb[3][$];
  fetch_responder_if b0 ();
  fetch_responder_if b1 ();
  fetch_responder_if b2 ();
  assign b0.adr = adr[0];
  assign b0.size = size[0];
  assign b0.vpa = vpa[0];
  assign b1.adr = adr[1];
  assign b1.size = size[1];
  assign b1.vpa = vpa[1];
  assign b2.adr = adr[2];
  assign b2.size = size[2];
  assign b2.vpa = vpa[2];
  assign ack  = {b2.ack, b1.ack, b0.ack};
  assign err  = {b2.err, b1.err, b0.err};
  assign ferr = {b2.fetch_err, b1.fetch_err, b0.fetch_err};
  assign dat[0] = b0.dat;
  assign dat[1] = b1.dat;
  assign dat[2] = b2.dat;
  fetch_responder #(.WAIT_STATES(0)) u0 (.clk_i(clk_i), .reset_ni(rst_n), .bus(b0),
    .mem_en_o(mem_en[0]), .mem_adr_o(madr[0]), .mem_dat_i(mdat[0]));
  fetch_responder #(.WAIT_STATES(3)) u3 (.clk_i(clk_i), .reset_ni(rst_n), .bus(b1),
    .mem_en_o(mem_en[1]), .mem_adr_o(madr[1]), .mem_dat_i(mdat[1]));
  fetch_responder #(.WAIT_STATES(5)) u5 (.clk_i(clk_i), .reset_ni(rst_n), .bus(b2),
    .mem_en_o(mem_en[2]), .mem_adr_o(madr[2]), .mem_dat_i(mdat[2]));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) for (int k = 0; k < 3; k++) if (mem_en[k]) mdat[k] <= mem[madr[k]];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at cycle %0d", n, a, x, cyc);
    end
  endtask
  always @(negedge clk_i) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin
        if (sb[k].size() == 0) chk("spurious_ack", 32'd1, 32'd0);
        else begin
          e = sb[k].pop_front();
          chk("dat", 32'(dat[k]), 32'(e.dat));
          chk("err", 32'(err[k]), 32'(e.err));
          chk("fetch_err", 32'(ferr[k]), 32'(e.ferr));
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end else if (err[k] || ferr[k]) chk("err_without_ack", {30'd0, err[k], ferr[k]}, 32'd0);
    end
  end
  task automatic req(input int k, input logic [63:0] a, input logic [1:0] s, input logic v,
                     input logic [15:0] d, input logic e, input logic fe, input int lat, input logic en);
    bit got = 1'b0;
    adr[k] = a;
    size[k] = s;
    vpa[k] = v;
    sb[k].push_back('{d, e, fe, lat, cyc});
    @(negedge clk_i);
    chk("mem_en", 32'(mem_en[k]), 32'(en));
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      got = ack[k];
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle(input int k);
    size[k] = SIZE_NONE;
    vpa[k] = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 16'h5A00 ^ 16'(i);
    mem[0] = 16'h0013;
    mem[1] = 16'h2345;
    mem[2] = 16'hABCD;
    mem[127] = 16'h7E57;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0;
      size[k] = SIZE_NONE;
      vpa[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", 32'(ack[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_fetch_err", 32'(ferr[k]), 32'd0);
      chk("rst_dat", 32'(dat[k]), 32'd0);
    end
    #12 rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    req(0, B, SIZE_HALF, 1'b1, 16'h0013, 1'b0, 1'b0, 2, 1'b1);
    req(0, 64'h1000, SIZE_HALF, 1'b1, 16'h0000, 1'b1, 1'b1, 1, 1'b0);
    req(0, B + 64'd5, SIZE_BYTE, 1'b0, 16'h00AB, 1'b0, 1'b0, 2, 1'b1);
    req(0, B + 64'd4, SIZE_BYTE, 1'b0, 16'h00CD, 1'b0, 1'b0, 2, 1'b1);
    req(0, B + 64'd4, SIZE_ILL, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    req(0, 64'hFFFF_FFFF_FFFF_FFFE, SIZE_HALF, 1'b0, 16'h7E57, 1'b0, 1'b0, 2, 1'b1);
    req(0, 64'h0, SIZE_HALF, 1'b1, 16'h0000, 1'b1, 1'b1, 1, 1'b0);
    req(0, 64'hFFFF_FFFF_FFFF_FEFE, SIZE_HALF, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    idle(0);
    req(1, B, SIZE_HALF, 1'b1, 16'h0013, 1'b0, 1'b0, 5, 1'b1);
    req(1, B + 64'd2, SIZE_HALF, 1'b1, 16'h2345, 1'b0, 1'b0, 5, 1'b1);
    idle(1);
    adr[2] = B;
    size[2] = SIZE_HALF;
    vpa[2] = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    idle(2);
    n = 0;
    repeat (15) begin
      @(negedge clk_i);
      n += int'(ack[2]);
    end
    chk("abort_no_ack", 32'(n), 32'd0);
    @(posedge clk_i);
    #1;
    req(2, B + 64'd2, SIZE_HALF, 1'b0, 16'h2345, 1'b0, 1'b0, 7, 1'b1);
    idle(2);
    adr[1] = B;
    size[1] = SIZE_HALF;
    @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1;
    chk("midread_rst_ack", 32'(ack[1]), 32'd0);
    chk("midread_rst_dat", 32'(dat[1]), 32'd0);
    chk("midread_rst_idle_mem_en", 32'(mem_en[1]), 32'd1);
    idle(1);
    #1 rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk_i);
      n += int'(ack[1]);
    end
    chk("post_rst_no_ack", 32'(n), 32'd0);
    for (int k = 0; k < 3; k++) chk("scoreboard_empty", 32'(sb[k].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
